// File: rtl/shift_add_mult_4b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_4b (with leaf adder_4b)
// Brief    : Sequential 4x4 unsigned shift-add multiplier around one 4-bit
//            ripple adder. Optional macro MULT_EARLY_TERM_EN collapses the
//            trailing zero-bit iterations into one combined shift.
// Revision : 1.0 - initial release
// ============================================================================

module adder_4b (
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    output logic [3:0] out,
    output logic       cout
);
    logic [4:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign out[i]       = num1[i] ^ num2[i] ^ w_carry[i];
        assign w_carry[i+1] = (num1[i] & num2[i]) | (w_carry[i] & (num1[i] ^ num2[i]));
    end

    assign cout = w_carry[4];
endmodule

module shift_add_mult_4b #(
    parameter int DONE_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] m_q,     m_d;
    logic [3:0] acc_q,   acc_d;
    logic [3:0] qreg_q,  qreg_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic [3:0] w_addend;
    logic [3:0] w_sum;
    logic       w_cout;
    logic [8:0] w_ext;
    logic [7:0] w_shifted;
    logic [2:0] w_shamt;
    logic       w_last;

    assign w_addend = qreg_q[0] ? m_q : 4'h0;

    adder_4b u_adder (
        .num1 (acc_q),
        .num2 (w_addend),
        .out  (w_sum),
        .cout (w_cout)
    );

    // Carry is shifted straight into A[3] in the same cycle, so the {C,A,Q}
    // carry bit never needs to outlive the cycle and has no flop of its own.
    assign w_ext = {w_cout, w_sum, qreg_q};

`ifdef MULT_EARLY_TERM_EN
    logic [3:0] w_pending;
    logic       w_rest_zero;

    // Unconsumed multiplier bits sit in Q[3-cnt:1]; once they are all zero
    // the remaining iterations are pure shifts and can be done at once.
    assign w_pending   = (qreg_q >> 1) & (4'b0111 >> cnt_q);
    assign w_rest_zero = (w_pending == 4'h0);
    assign w_shamt     = w_rest_zero ? (3'd4 - cnt_q) : 3'd1;
    assign w_last      = w_rest_zero || (cnt_q == 3'd3);
`else
    assign w_shamt     = 3'd1;
    assign w_last      = (cnt_q == 3'd3);
`endif

    assign w_shifted = 8'(w_ext >> w_shamt);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qreg_d  = qreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    qreg_d  = b;
                    acc_d   = 4'h0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end else if (DONE_HOLD == 0) begin
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                acc_d  = w_shifted[7:4];
                qreg_d = w_shifted[3:0];
                cnt_d  = cnt_q + 3'd1;
                if (w_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= 4'h0;
            acc_q   <= 4'h0;
            qreg_q  <= 4'h0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qreg_q  <= qreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign product = {acc_q, qreg_q};
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult_4b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult_4b
// Brief    : Scoreboard bench driving a pulse-done and a held-done instance
//            of shift_add_mult_4b with one shared stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================

module tb_shift_add_mult_4b;
    typedef struct {
        logic [7:0] p;
        int         acc_cyc;
        int         done_cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] product0, product1;
    logic       busy0, busy1;
    logic       done0, done1;

    int   cyc;
    int   last_acc;
    int   n_vec;
    int   n_bad;
    bit   end_req;
    exp_t q[$];

    shift_add_mult_4b #(.DONE_HOLD(0)) u_dut_pulse (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product0),
        .busy    (busy0),
        .done    (done0)
    );

    shift_add_mult_4b #(.DONE_HOLD(1)) u_dut_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product1),
        .busy    (busy1),
        .done    (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [3:0] bv);
        int l;
        l = 5;
`ifdef MULT_EARLY_TERM_EN
        l = 2;
        for (int i = 0; i < 4; i++) begin
            if (bv[i]) l = 2 + i;
        end
`endif
        return l;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp_v, exp_v, cyc);
        end
    endtask

    // Issue one operation; returns at #1 after the FIN->IDLE edge.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] pexp, input bit keep);
        exp_t e;
        int   l;
        l          = lat_of(bv);
        a          = av;
        b          = bv;
        start      = 1'b1;
        e.p        = pexp;
        e.acc_cyc  = cyc + 1;
        e.done_cyc = cyc + 1 + l;
        last_acc   = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        a = ~av;
        b = 4'($urandom);
        repeat (l) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic d0_prev, d1_prev;
        bit   exp_busy;
        d0_prev = 1'b0;
        d1_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (end_req) begin
                chk("pending_ops", q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                $finish;
            end
            if (!rst_n) begin
                chk("rst_product_pulse", int'(product0), 0);
                chk("rst_product_hold",  int'(product1), 0);
                chk("rst_busy",          int'(busy0 | busy1), 0);
                chk("rst_done",          int'(done0 | done1), 0);
                d0_prev = 1'b0;
                d1_prev = 1'b0;
            end else begin
                if (q.size() > 0) begin
                    exp_busy = (cyc >= q[0].acc_cyc) && (cyc < q[0].done_cyc);
                    chk("busy_pulse", int'(busy0), int'(exp_busy));
                    chk("busy_hold",  int'(busy1), int'(exp_busy));
                end
                if (done0 && !d0_prev) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("product_pulse", int'(product0), int'(e.p));
                        chk("product_hold",  int'(product1), int'(e.p));
                        chk("latency",       cyc, e.done_cyc);
                        chk("done_hold_set", int'(done1), 1);
                    end
                end
                if (d0_prev) chk("done_pulse_width", int'(done0), 0);
                if (d1_prev && !done1) chk("done_hold_release", cyc, last_acc);
                d0_prev = done0;
                d1_prev = done1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its end within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        n_vec    = 0;
        n_bad    = 0;
        end_req  = 1'b0;
        last_acc = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort a 15*15 run two cycles in; outputs must clear before any edge.
        a = 4'hF; b = 4'hF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'd13, 4'd11, 8'h8F, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        run_op(4'hF, 4'hF, 8'hE1, 1'b0);
        run_op(4'hF, 4'h0, 8'h00, 1'b0);
        run_op(4'h1, 4'hF, 8'h0F, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        run_op(4'd7, 4'd6, 8'h2A, 1'b1);
        run_op(4'd3, 4'd5, 8'h0F, 1'b1);
        run_op(4'd9, 4'd9, 8'h51, 1'b0);
        run_op(4'hA, 4'h1, 8'h0A, 1'b0);
        run_op(4'd5, 4'h8, 8'h28, 1'b0);
        run_op(4'h0, 4'h0, 8'h00, 1'b0);

        for (int i = 0; i < 256; i++) begin
            run_op(4'(i >> 4), 4'(i), 8'((i >> 4) * (i & 15)), (i != 255));
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        end_req = 1'b1;
    end
endmodule

`default_nettype wire
